// File: rtl/pipe_tracker_if.sv
// Bundle between fetch/control logic and the instruction-tracking pipeline.
// The master side drives fetch fields and control; the slave side is the tracker itself.
interface pipe_tracker_if #(
   parameter int DATA_W = 8,
   parameter int STAGES = 4,
   parameter int RA_W   = 2
);
   localparam int SW = $clog2(STAGES);

   logic                     in_valid;
   logic [DATA_W-1:0]        in_instr;
   logic [DATA_W-1:0]        in_pc;
   logic                     in_wr;
   logic [RA_W-1:0]          in_dst;
   logic [RA_W-1:0]          in_src1;
   logic [RA_W-1:0]          in_src2;
   logic                     hold;
   logic                     flush;
   logic                     retire_stop;
   logic [STAGES-1:0]        stage_valid;
   logic [STAGES*DATA_W-1:0] stage_instr;
   logic [STAGES*DATA_W-1:0] stage_pc;
   logic [STAGES-1:0]        load_en;
   logic [SW-1:0]            byp1_stage;
   logic [SW-1:0]            byp2_stage;
   logic                     stopped;
   logic [15:0]              cycle_count;
   logic [15:0]              retire_count;
   logic [15:0]              bubble_count;

   modport master (
      output in_valid, in_instr, in_pc, in_wr, in_dst, in_src1, in_src2,
      output hold, flush, retire_stop,
      input  stage_valid, stage_instr, stage_pc, load_en, byp1_stage, byp2_stage,
      input  stopped, cycle_count, retire_count, bubble_count
   );

   modport slave (
      input  in_valid, in_instr, in_pc, in_wr, in_dst, in_src1, in_src2,
      input  hold, flush, retire_stop,
      output stage_valid, stage_instr, stage_pc, load_en, byp1_stage, byp2_stage,
      output stopped, cycle_count, retire_count, bubble_count
   );
endinterface

// File: rtl/pipe_tracker.sv
// Instruction-tracking pipeline: per-stage valid/instr/pc/register metadata with hold,
// branch flush, read-stage forwarding selection and saturating performance counters.
module pipe_tracker #(
   parameter int DATA_W      = 8,
   parameter int STAGES      = 4,
   parameter int RA_W        = 2,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic          clock,
   input  logic          reset,
   pipe_tracker_if.slave bus
);
   localparam int SW = $clog2(STAGES);

   logic [STAGES-1:0]        valid_all;
   logic [STAGES-1:0]        wr_all;
   logic [STAGES*DATA_W-1:0] instr_all;
   logic [STAGES*DATA_W-1:0] pc_all;
   logic [STAGES*RA_W-1:0]   dst_all;
   logic [STAGES*RA_W-1:0]   src1_all;
   logic [STAGES*RA_W-1:0]   src2_all;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         // Running flush kills one stage deeper than a held flush, since the
         // stage at FLUSH_DEPTH would otherwise take in a wrong-path instruction.
         localparam bit KILL_RUN  = (gi <= FLUSH_DEPTH);
         localparam bit KILL_HOLD = (gi < FLUSH_DEPTH);

         logic              s_valid, s_wr;
         logic [DATA_W-1:0] s_instr, s_pc;
         logic [RA_W-1:0]   s_dst, s_src1, s_src2;
         logic              valid_q, valid_d, wr_q;
         logic [DATA_W-1:0] instr_q, pc_q;
         logic [RA_W-1:0]   dst_q, src1_q, src2_q;

         if (gi == 0) begin : g_head
            assign s_valid = bus.in_valid;
            assign s_wr    = bus.in_wr;
            assign s_instr = bus.in_instr;
            assign s_pc    = bus.in_pc;
            assign s_dst   = bus.in_dst;
            assign s_src1  = bus.in_src1;
            assign s_src2  = bus.in_src2;
         end else begin : g_body
            assign s_valid = valid_all[gi-1];
            assign s_wr    = wr_all[gi-1];
            assign s_instr = instr_all[(gi-1)*DATA_W +: DATA_W];
            assign s_pc    = pc_all[(gi-1)*DATA_W +: DATA_W];
            assign s_dst   = dst_all[(gi-1)*RA_W +: RA_W];
            assign s_src1  = src1_all[(gi-1)*RA_W +: RA_W];
            assign s_src2  = src2_all[(gi-1)*RA_W +: RA_W];
         end

         always_comb begin
            valid_d = valid_q;
            if (bus.hold) begin
               if (bus.flush && KILL_HOLD) valid_d = 1'b0;
            end else begin
               valid_d = s_valid && !(bus.flush && KILL_RUN);
            end
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               valid_q <= 1'b0;
               wr_q    <= 1'b0;
               instr_q <= '0;
               pc_q    <= '0;
               dst_q   <= '0;
               src1_q  <= '0;
               src2_q  <= '0;
            end else begin
               valid_q <= valid_d;
               if (!bus.hold) begin
                  wr_q    <= s_wr;
                  instr_q <= s_instr;
                  pc_q    <= s_pc;
                  dst_q   <= s_dst;
                  src1_q  <= s_src1;
                  src2_q  <= s_src2;
               end
            end
         end

         assign valid_all[gi]                   = valid_q;
         assign wr_all[gi]                      = wr_q;
         assign instr_all[gi*DATA_W +: DATA_W]  = instr_q;
         assign pc_all[gi*DATA_W +: DATA_W]     = pc_q;
         assign dst_all[gi*RA_W +: RA_W]        = dst_q;
         assign src1_all[gi*RA_W +: RA_W]       = src1_q;
         assign src2_all[gi*RA_W +: RA_W]       = src2_q;
      end
   endgenerate

   // Scan oldest to youngest so the youngest matching producer is left standing.
   logic [SW-1:0] byp1_d, byp2_d;
   always_comb begin
      byp1_d = '0;
      byp2_d = '0;
      if (valid_all[1]) begin
         for (int j = STAGES - 1; j >= 2; j--) begin
            if (valid_all[j] && wr_all[j] && (dst_all[j*RA_W +: RA_W] == src1_all[RA_W +: RA_W]))
               byp1_d = SW'(j);
            if (valid_all[j] && wr_all[j] && (dst_all[j*RA_W +: RA_W] == src2_all[RA_W +: RA_W]))
               byp2_d = SW'(j);
         end
      end
   end

   logic        stopped_q;
   logic [15:0] cycle_q, retire_q, bubble_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stopped_q <= 1'b0;
         cycle_q   <= '0;
         retire_q  <= '0;
         bubble_q  <= '0;
      end else begin
         if (!stopped_q) begin
            if (cycle_q != 16'hFFFF) cycle_q <= cycle_q + 16'd1;
            if (!bus.hold) begin
               if (valid_all[STAGES-1]) begin
                  if (retire_q != 16'hFFFF) retire_q <= retire_q + 16'd1;
               end else begin
                  if (bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
               end
            end
         end
         if (bus.retire_stop) stopped_q <= 1'b1;
      end
   end

   assign bus.stage_valid  = valid_all;
   assign bus.stage_instr  = instr_all;
   assign bus.stage_pc     = pc_all;
   assign bus.load_en      = bus.hold ? '0 : '1;
   assign bus.byp1_stage   = byp1_d;
   assign bus.byp2_stage   = byp2_d;
   assign bus.stopped      = stopped_q;
   assign bus.cycle_count  = cycle_q;
   assign bus.retire_count = retire_q;
   assign bus.bubble_count = bubble_q;
endmodule

// File: tb/tb_pipe_tracker.sv
// Directed bench for pipe_tracker at default parameters: fill, hold, flush,
// forwarding, stop, counter saturation and asynchronous reset.
module tb_pipe_tracker;
   logic clock;
   logic reset;
   int   checks;
   int   failures;

   pipe_tracker_if #(.DATA_W(8), .STAGES(4), .RA_W(2)) bus ();

   pipe_tracker #(.DATA_W(8), .STAGES(4), .RA_W(2), .FLUSH_DEPTH(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic drive(input logic v, input logic [7:0] instr, input logic wr,
                        input logic [1:0] dst, input logic [1:0] s1, input logic [1:0] s2);
      bus.in_valid = v;
      bus.in_instr = instr;
      bus.in_pc    = instr + 8'd1;
      bus.in_wr    = wr;
      bus.in_dst   = dst;
      bus.in_src1  = s1;
      bus.in_src2  = s2;
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.hold = 1'b0;
      bus.flush = 1'b0;
      bus.retire_stop = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      #3;
      checks++; if (bus.stage_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%h exp=0", bus.stage_valid); end
      checks++; if (bus.stage_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.stage_instr); end
      checks++; if (bus.stage_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.stage_pc); end
      checks++; if ({bus.cycle_count, bus.retire_count, bus.bubble_count} !== 48'h0) begin failures++; $display("FAIL reset_counters got=%h/%h/%h exp=0", bus.cycle_count, bus.retire_count, bus.bubble_count); end
      checks++; if ({bus.stopped, bus.byp1_stage, bus.byp2_stage} !== 5'b0) begin failures++; $display("FAIL reset_stop_byp got=%b/%0d/%0d exp=0", bus.stopped, bus.byp1_stage, bus.byp2_stage); end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_fill();
      drive(1'b1, 8'h11, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      drive(1'b1, 8'h22, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      drive(1'b1, 8'h33, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      drive(1'b1, 8'h44, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      checks++; if (bus.stage_instr !== 32'h11223344) begin failures++; $display("FAIL fill_instr got=%h exp=11223344", bus.stage_instr); end
      checks++; if (bus.stage_valid !== 4'b1111) begin failures++; $display("FAIL fill_valid got=%b exp=1111", bus.stage_valid); end
      checks++; if (bus.retire_count !== 16'd0) begin failures++; $display("FAIL fill_retire4 got=%0d exp=0", bus.retire_count); end
      drive(1'b1, 8'h55, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      checks++; if (bus.retire_count !== 16'd1) begin failures++; $display("FAIL fill_retire5 got=%0d exp=1", bus.retire_count); end
      checks++; if (bus.bubble_count !== 16'd4 || bus.cycle_count !== 16'd5) begin failures++; $display("FAIL fill_counts got=bub%0d cyc%0d exp=bub4 cyc5", bus.bubble_count, bus.cycle_count); end
      checks++; if (bus.stage_instr !== 32'h22334455) begin failures++; $display("FAIL fill_shift got=%h exp=22334455", bus.stage_instr); end
      checks++; if (bus.stage_pc !== 32'h23344556) begin failures++; $display("FAIL fill_pc got=%h exp=23344556", bus.stage_pc); end
   endtask

   task automatic test_hold();
      drive(1'b1, 8'h66, 1'b0, 2'd0, 2'd0, 2'd0);
      bus.hold = 1'b1;
      #1;
      checks++; if (bus.load_en !== 4'b0000) begin failures++; $display("FAIL hold_load_en got=%b exp=0000", bus.load_en); end
      step(3);
      checks++; if (bus.stage_instr !== 32'h22334455 || bus.stage_valid !== 4'b1111) begin failures++; $display("FAIL hold_contents got=%h/%b exp=22334455/1111", bus.stage_instr, bus.stage_valid); end
      checks++; if (bus.retire_count !== 16'd1 || bus.bubble_count !== 16'd4) begin failures++; $display("FAIL hold_counts got=ret%0d bub%0d exp=ret1 bub4", bus.retire_count, bus.bubble_count); end
      checks++; if (bus.cycle_count !== 16'd8) begin failures++; $display("FAIL hold_cycle got=%0d exp=8", bus.cycle_count); end
      bus.hold = 1'b0;
      #1;
      checks++; if (bus.load_en !== 4'b1111) begin failures++; $display("FAIL run_load_en got=%b exp=1111", bus.load_en); end
   endtask

   task automatic test_flush();
      drive(1'b1, 8'h77, 1'b0, 2'd0, 2'd0, 2'd0);
      bus.flush = 1'b1;
      step(1);
      bus.flush = 1'b0;
      checks++; if (bus.stage_valid !== 4'b1000) begin failures++; $display("FAIL flush_run_valid got=%b exp=1000", bus.stage_valid); end
      checks++; if (bus.stage_instr[31:24] !== 8'h33) begin failures++; $display("FAIL flush_run_stage3 got=%h exp=33", bus.stage_instr[31:24]); end
      drive(1'b1, 8'h81, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      drive(1'b1, 8'h82, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      drive(1'b1, 8'h83, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      drive(1'b1, 8'h84, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      drive(1'b1, 8'h99, 1'b0, 2'd0, 2'd0, 2'd0);
      bus.hold = 1'b1;
      bus.flush = 1'b1;
      step(1);
      bus.hold = 1'b0;
      bus.flush = 1'b0;
      checks++; if (bus.stage_valid !== 4'b1100) begin failures++; $display("FAIL flush_hold_valid got=%b exp=1100", bus.stage_valid); end
      checks++; if (bus.stage_instr !== 32'h81828384) begin failures++; $display("FAIL flush_hold_instr got=%h exp=81828384", bus.stage_instr); end
   endtask

   // Loads four entries oldest first: after the call A sits in stage 3, D in stage 0.
   task automatic load4(input logic a_wr, input logic [1:0] a_dst,
                        input logic b_wr, input logic [1:0] b_dst,
                        input logic c_v, input logic [1:0] c_s1, input logic [1:0] c_s2);
      drive(1'b1, 8'hA0, a_wr, a_dst, 2'd0, 2'd0); step(1);
      drive(1'b1, 8'hB0, b_wr, b_dst, 2'd0, 2'd0); step(1);
      drive(c_v,  8'hC0, 1'b0, 2'd0, c_s1, c_s2);  step(1);
      drive(1'b0, 8'hD0, 1'b0, 2'd0, 2'd0, 2'd0);  step(1);
   endtask

   task automatic test_forward();
      load4(1'b0, 2'd2, 1'b1, 2'd2, 1'b1, 2'd2, 2'd3);
      checks++; if (bus.byp1_stage !== 2'd2) begin failures++; $display("FAIL fwd_stage2 got=%0d exp=2", bus.byp1_stage); end
      checks++; if (bus.byp2_stage !== 2'd0) begin failures++; $display("FAIL fwd_src2_none got=%0d exp=0", bus.byp2_stage); end
      load4(1'b1, 2'd2, 1'b1, 2'd2, 1'b1, 2'd2, 2'd3);
      checks++; if (bus.byp1_stage !== 2'd2) begin failures++; $display("FAIL fwd_youngest got=%0d exp=2", bus.byp1_stage); end
      load4(1'b1, 2'd2, 1'b0, 2'd2, 1'b1, 2'd2, 2'd1);
      checks++; if (bus.byp1_stage !== 2'd3) begin failures++; $display("FAIL fwd_stage3 got=%0d exp=3", bus.byp1_stage); end
      checks++; if (bus.byp2_stage !== 2'd0) begin failures++; $display("FAIL fwd_src2_miss got=%0d exp=0", bus.byp2_stage); end
      load4(1'b1, 2'd1, 1'b1, 2'd3, 1'b1, 2'd1, 2'd3);
      checks++; if (bus.byp1_stage !== 2'd3 || bus.byp2_stage !== 2'd2) begin failures++; $display("FAIL fwd_both got=%0d/%0d exp=3/2", bus.byp1_stage, bus.byp2_stage); end
      load4(1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 2'd2, 2'd2);
      checks++; if (bus.byp1_stage !== 2'd0 || bus.byp2_stage !== 2'd0) begin failures++; $display("FAIL fwd_read_invalid got=%0d/%0d exp=0/0", bus.byp1_stage, bus.byp2_stage); end
   endtask

   task automatic test_stop();
      drive(1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      pulse_reset();
      step(3);
      bus.retire_stop = 1'b1;
      step(1);
      bus.retire_stop = 1'b0;
      checks++; if (bus.stopped !== 1'b1) begin failures++; $display("FAIL stop_flag got=%b exp=1", bus.stopped); end
      checks++; if (bus.cycle_count !== 16'd4 || bus.bubble_count !== 16'd4 || bus.retire_count !== 16'd0) begin failures++; $display("FAIL stop_counts got=%0d/%0d/%0d exp=4/4/0", bus.cycle_count, bus.bubble_count, bus.retire_count); end
      drive(1'b1, 8'h9A, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      drive(1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      checks++; if (bus.stage_valid !== 4'b0010 || bus.stage_instr[15:8] !== 8'h9A) begin failures++; $display("FAIL stop_shift got=%b/%h exp=0010/9a", bus.stage_valid, bus.stage_instr[15:8]); end
      checks++; if (bus.cycle_count !== 16'd4 || bus.bubble_count !== 16'd4 || bus.stopped !== 1'b1) begin failures++; $display("FAIL stop_frozen got=cyc%0d bub%0d stop%b exp=cyc4 bub4 stop1", bus.cycle_count, bus.bubble_count, bus.stopped); end
   endtask

   task automatic test_saturation();
      drive(1'b0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      pulse_reset();
      step(65534);
      checks++; if (bus.cycle_count !== 16'hFFFE || bus.bubble_count !== 16'hFFFE) begin failures++; $display("FAIL sat_before got=%h/%h exp=fffe/fffe", bus.cycle_count, bus.bubble_count); end
      step(3);
      checks++; if (bus.cycle_count !== 16'hFFFF || bus.bubble_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h/%h exp=ffff/ffff", bus.cycle_count, bus.bubble_count); end
      checks++; if (bus.retire_count !== 16'd0) begin failures++; $display("FAIL sat_retire got=%0d exp=0", bus.retire_count); end
   endtask

   task automatic test_async_reset();
      pulse_reset();
      drive(1'b1, 8'h5A, 1'b1, 2'd1, 2'd1, 2'd1); step(1);
      drive(1'b1, 8'h6B, 1'b0, 2'd0, 2'd1, 2'd1); step(1);
      drive(1'b1, 8'h7C, 1'b0, 2'd0, 2'd0, 2'd0); step(1);
      bus.retire_stop = 1'b1; step(1);
      bus.retire_stop = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++; if (bus.stage_valid !== 4'h0 || bus.stage_instr !== 32'h0 || bus.stage_pc !== 32'h0) begin failures++; $display("FAIL async_stages got=%b/%h/%h exp=0", bus.stage_valid, bus.stage_instr, bus.stage_pc); end
      checks++; if ({bus.cycle_count, bus.retire_count, bus.bubble_count} !== 48'h0 || bus.stopped !== 1'b0) begin failures++; $display("FAIL async_counters got=%h/%h/%h stop%b exp=0", bus.cycle_count, bus.retire_count, bus.bubble_count, bus.stopped); end
      checks++; if (bus.byp1_stage !== 2'd0 || bus.byp2_stage !== 2'd0) begin failures++; $display("FAIL async_byp got=%0d/%0d exp=0/0", bus.byp1_stage, bus.byp2_stage); end
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_fill();
      test_hold();
      test_flush();
      test_forward();
      test_stop();
      test_saturation();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
